pic_rw_cmd_sequencer: RTL and testbench

// Bus-side front end of the 8259-style PIC, directly upstream of the control-logic block.

---
 rtl/pic_rw_cmd_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pic_rw_cmd_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_rw_cmd_sequencer.sv
// Bus-side front end of an 8259-style PIC.
// Synchronises the CPU strobes, captures written bytes, steps through the
// ICW1..ICW4 initialisation sequence, classifies every write as ICW/OCW with
// a 3-bit word code, and drives the register-read select for the data mux.
//
// Handshake: there is no back-pressure. cw_strobe is a one-cycle valid pulse;
// cw_data/cw_flag are valid in that cycle and hold until the next pulse.
module pic_rw_cmd_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic       a0,
    input  logic [7:0] data_in,
    output logic [7:0] cw_data,
    output logic [2:0] cw_flag,
    output logic       cw_strobe,
    output logic [2:0] read_sel,
    output logic       rd_active,
    output logic       init_done
);

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    localparam logic [2:0] FLAG_NONE = 3'd7;

    logic       s_cs_n, s_wr_n, s_rd_n, s_a0;
    logic       prev_wr_n;
    logic       cap_valid;
    logic       cap_a0;
    logic [7:0] cap_data;
    logic       wr_event;
    logic       is_icw1;
    logic       qual_read;
    logic [2:0] next_flag;
    state_t     state;
    logic       sngl;
    logic       ic4;
    logic       sel_isr;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign {s_cs_n, s_wr_n, s_rd_n, s_a0} = {cs_n, wr_n, rd_n, a0};
        end else begin : g_sync
            // Bundle order {cs_n, wr_n, rd_n, a0}; idle value keeps strobes inactive.
            logic [3:0] sync_q [SYNC_STAGES];

            // Shift the raw bus controls through the synchroniser chain.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1110;
                end else begin
                    sync_q[0] <= {cs_n, wr_n, rd_n, a0};
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign {s_cs_n, s_wr_n, s_rd_n, s_a0} = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign wr_event  = s_wr_n && !prev_wr_n && cap_valid;
    assign is_icw1   = !cap_a0 && cap_data[4];
    assign qual_read = !s_rd_n && !s_cs_n && s_wr_n;

    // Capture the byte while a selected write is low; losing cs_n aborts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_wr_n <= 1'b1;
            cap_valid <= 1'b0;
            cap_a0    <= 1'b0;
            cap_data  <= 8'h00;
        end else begin
            prev_wr_n <= s_wr_n;
            if (!s_wr_n && !s_cs_n) begin
                cap_valid <= 1'b1;
                cap_data  <= data_in;
                cap_a0    <= s_a0;
            end else if (!s_wr_n && s_cs_n) begin
                cap_valid <= 1'b0;
            end else if (wr_event) begin
                cap_valid <= 1'b0;
            end
        end
    end

    // Word code the captured byte would get in the current state (7 = ignored).
    always_comb begin
        next_flag = FLAG_NONE;
        if (is_icw1) begin
            next_flag = 3'd0;
        end else begin
            case (state)
                ST_WAIT_ICW2: if (cap_a0) next_flag = 3'd1;
                ST_WAIT_ICW3: if (cap_a0) next_flag = 3'd2;
                ST_WAIT_ICW4: if (cap_a0) next_flag = 3'd3;
                ST_READY:     next_flag = cap_a0 ? 3'd4 : (cap_data[3] ? 3'd6 : 3'd5);
                default:      next_flag = FLAG_NONE;
            endcase
        end
    end

    // Init-sequence FSM with registered command-word outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_UNINIT;
            sngl      <= 1'b0;
            ic4       <= 1'b0;
            sel_isr   <= 1'b0;
            init_done <= 1'b0;
            cw_data   <= 8'h00;
            cw_flag   <= FLAG_NONE;
            cw_strobe <= 1'b0;
        end else begin
            cw_strobe <= 1'b0;
            if (wr_event && next_flag != FLAG_NONE) begin
                cw_strobe <= 1'b1;
                cw_flag   <= next_flag;
                cw_data   <= cap_data;
                if (is_icw1) begin
                    state     <= ST_WAIT_ICW2;
                    sngl      <= cap_data[1];
                    ic4       <= cap_data[0];
                    init_done <= 1'b0;
                    sel_isr   <= 1'b0;
                end else begin
                    case (state)
                        ST_WAIT_ICW2: begin
                            if (!sngl) begin
                                state <= ST_WAIT_ICW3;
                            end else if (ic4) begin
                                state <= ST_WAIT_ICW4;
                            end else begin
                                state     <= ST_READY;
                                init_done <= 1'b1;
                            end
                        end
                        ST_WAIT_ICW3: begin
                            if (ic4) begin
                                state <= ST_WAIT_ICW4;
                            end else begin
                                state     <= ST_READY;
                                init_done <= 1'b1;
                            end
                        end
                        ST_WAIT_ICW4: begin
                            state     <= ST_READY;
                            init_done <= 1'b1;
                        end
                        ST_READY: begin
                            // OCW3 with RR set picks IRR/ISR via RIS; RR clear keeps it.
                            if (!cap_a0 && cap_data[3] && cap_data[1]) sel_isr <= cap_data[0];
                        end
                        default: state <= ST_UNINIT;
                    endcase
                end
            end
        end
    end

    // Register the read select one cycle behind the synchronised strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_active <= 1'b0;
            read_sel  <= 3'b000;
        end else begin
            rd_active <= qual_read;
            if (!qual_read)  read_sel <= 3'b000;
            else if (s_a0)   read_sel <= 3'b011;
            else if (sel_isr) read_sel <= 3'b101;
            else             read_sel <= 3'b001;
        end
    end

endmodule

// File: tb/tb_pic_rw_cmd_sequencer.sv
// Testbench for pic_rw_cmd_sequencer: directed init/OCW scenarios followed by
// randomized bus traffic, all compared every cycle against a transaction-level
// model of the PIC's command-word rules.
module tb_pic_rw_cmd_sequencer;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] cw_data;
    logic [2:0] cw_flag;
    logic       cw_strobe;
    logic [2:0] read_sel;
    logic       rd_active;
    logic       init_done;

    pic_rw_cmd_sequencer #(.SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .a0(a0), .data_in(data_in), .cw_data(cw_data), .cw_flag(cw_flag),
        .cw_strobe(cw_strobe), .read_sel(read_sel), .rd_active(rd_active),
        .init_done(init_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         due;
        logic [2:0] flag;
        logic [7:0] data;
        logic       init;
        logic       isr;
    } ev_t;

    ev_t exp_q[$];

    // Model of the programming state as seen by the CPU.
    int   m_next = 0;      // 0: not initialised, 2..4: ICW expected next, 5: operational
    logic m_sngl = 1'b0;
    logic m_ic4  = 1'b0;
    logic m_init = 1'b0;
    logic m_isr  = 1'b0;

    // Values the outputs must currently show.
    logic [2:0] cur_flag = 3'd7;
    logic [7:0] cur_data = 8'h00;
    logic       cur_init = 1'b0;
    logic       cur_isr  = 1'b0;
    logic       isr_prev = 1'b0;

    task automatic model_write(input logic wa0, input logic [7:0] d, input int due);
        logic [2:0] f;
        ev_t e;
        f = 3'd7;
        if (!wa0 && d[4]) begin
            m_sngl = d[1];
            m_ic4  = d[0];
            m_init = 1'b0;
            m_isr  = 1'b0;
            m_next = 2;
            f = 3'd0;
        end else if (m_next >= 2 && m_next <= 4) begin
            if (wa0) begin
                f = 3'(m_next - 1);
                if (m_next == 2 && !m_sngl) m_next = 3;
                else if (m_next <= 3 && m_ic4) m_next = 4;
                else begin
                    m_next = 5;
                    m_init = 1'b1;
                end
            end
        end else if (m_next == 5) begin
            if (wa0) f = 3'd4;
            else if (!d[3]) f = 3'd5;
            else begin
                f = 3'd6;
                if (d[1]) m_isr = d[0];
            end
        end
        if (f != 3'd7) begin
            e.due = due; e.flag = f; e.data = d; e.init = m_init; e.isr = m_isr;
            exp_q.push_back(e);
        end
    endtask

    // Raw bus history, one entry per falling edge.
    logic       h_cs [64];
    logic       h_wr [64];
    logic       h_rd [64];
    logic       h_a0 [64];
    logic [7:0] h_d  [64];
    int   cyc = 0;
    int   since_rst = 0;
    logic rst_prev = 1'b1;
    logic exp_strobe;
    logic exp_q_rd;
    logic [2:0] exp_rs;
    int   dut_strobes = 0;
    int   jj;
    int   pp;

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        h_cs[cyc % 64] = cs_n;
        h_wr[cyc % 64] = wr_n;
        h_rd[cyc % 64] = rd_n;
        h_a0[cyc % 64] = a0;
        h_d[cyc % 64]  = data_in;
        if (rst_prev) begin
            exp_q.delete();
            cur_flag = 3'd7; cur_data = 8'h00; cur_init = 1'b0; cur_isr = 1'b0;
            m_next = 0; m_sngl = 1'b0; m_ic4 = 1'b0; m_init = 1'b0; m_isr = 1'b0;
            since_rst = 0;
        end
        exp_strobe = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_strobe = 1'b1;
            cur_flag = exp_q[0].flag;
            cur_data = exp_q[0].data;
            cur_init = exp_q[0].init;
            cur_isr  = exp_q[0].isr;
            void'(exp_q.pop_front());
        end
        check("cw_strobe", 32'(cw_strobe), 32'(exp_strobe));
        check("cw_flag",   32'(cw_flag),   32'(cur_flag));
        check("cw_data",   32'(cw_data),   32'(cur_data));
        check("init_done", 32'(init_done), 32'(cur_init));
        if (cw_strobe) dut_strobes++;
        exp_q_rd = 1'b0;
        exp_rs   = 3'b000;
        if (since_rst > S) begin
            jj = (cyc - S - 1) % 64;
            exp_q_rd = !h_rd[jj] && !h_cs[jj] && h_wr[jj];
            if (exp_q_rd) exp_rs = h_a0[jj] ? 3'b011 : (isr_prev ? 3'b101 : 3'b001);
        end
        check("read_sel",  32'(read_sel),  32'(exp_rs));
        check("rd_active", 32'(rd_active), 32'(exp_q_rd));
        isr_prev = cur_isr;
        rst_prev = reset;
        if (!reset && cyc > 0) begin
            pp = (cyc - 1) % 64;
            if (h_wr[cyc % 64] && !h_wr[pp] && !h_cs[pp])
                model_write(h_a0[pp], h_d[pp], cyc + S + 1);
        end
        since_rst++;
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_write(input logic wa0, input logic [7:0] d);
        cs_n = 1'b0; a0 = wa0; data_in = d;
        tick(1);
        wr_n = 1'b0;
        tick(2);
        wr_n = 1'b1;
        tick(S + 3);
        cs_n = 1'b1;
        tick(2);
    endtask

    task automatic do_read(input logic ra0, output logic [2:0] rs, output logic act);
        cs_n = 1'b0; a0 = ra0;
        tick(1);
        rd_n = 1'b0;
        tick(S + 3);
        rs = read_sel; act = rd_active;
        rd_n = 1'b1;
        tick(1);
        cs_n = 1'b1;
        tick(S + 2);
    endtask

    task automatic do_overlap(input logic wa0, input logic [7:0] d,
                              output logic [2:0] rs, output logic act);
        cs_n = 1'b0; a0 = wa0; data_in = d;
        tick(1);
        wr_n = 1'b0; rd_n = 1'b0;
        tick(S + 3);
        rs = read_sel; act = rd_active;
        wr_n = 1'b1; rd_n = 1'b1;
        tick(S + 3);
        cs_n = 1'b1;
        tick(2);
    endtask

    task automatic do_abort(input logic wa0, input logic [7:0] d);
        cs_n = 1'b0; a0 = wa0; data_in = d;
        tick(1);
        wr_n = 1'b0;
        tick(2);
        cs_n = 1'b1;
        tick(1);
        wr_n = 1'b1;
        tick(S + 3);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int         base;
    logic [2:0] rs;
    logic       act;
    logic [7:0] rd8;
    int         r;

    initial begin
        tick(4);
        reset = 1'b0;
        tick(2);
        check("rst_cw_flag",   32'(cw_flag),   32'd7);
        check("rst_cw_data",   32'(cw_data),   32'd0);
        check("rst_read_sel",  32'(read_sel),  32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        // Non-ICW1 write out of reset is ignored.
        base = dut_strobes;
        do_write(1'b1, 8'h55);
        check("uninit_no_strobe", 32'(dut_strobes - base), 32'd0);
        check("uninit_flag",      32'(cw_flag),            32'd7);

        // Single, IC4: ICW1, ICW2, ICW4.
        base = dut_strobes;
        do_write(1'b0, 8'h13);
        check("single_icw1_flag", 32'(cw_flag), 32'd0);
        do_write(1'b1, 8'h20);
        check("single_icw2_flag", 32'(cw_flag), 32'd1);
        check("single_icw2_init", 32'(init_done), 32'd0);
        do_write(1'b1, 8'h01);
        check("single_strobes",   32'(dut_strobes - base), 32'd3);
        check("single_icw4_flag", 32'(cw_flag),   32'd3);
        check("single_icw4_data", 32'(cw_data),   32'h01);
        check("single_init_done", 32'(init_done), 32'd1);

        // Cascade, IC4: full four-word sequence, then OCW1.
        do_write(1'b0, 8'h11);
        do_write(1'b1, 8'h08);
        do_write(1'b1, 8'h04);
        check("cascade_icw3_flag", 32'(cw_flag), 32'd2);
        do_write(1'b1, 8'h01);
        check("cascade_init_done", 32'(init_done), 32'd1);
        do_write(1'b1, 8'hFE);
        check("ocw1_flag", 32'(cw_flag), 32'd4);
        check("ocw1_data", 32'(cw_data), 32'hFE);

        // OCW2, OCW3 selecting ISR, then reads.
        do_write(1'b0, 8'h20);
        check("ocw2_flag", 32'(cw_flag), 32'd5);
        do_write(1'b0, 8'h0B);
        check("ocw3_flag", 32'(cw_flag), 32'd6);
        do_read(1'b0, rs, act);
        check("read_isr_sel", 32'(rs),  32'b101);
        check("read_isr_act", 32'(act), 32'd1);
        do_read(1'b1, rs, act);
        check("read_imr_sel", 32'(rs),  32'b011);
        do_write(1'b0, 8'h0A);
        do_read(1'b0, rs, act);
        check("read_irr_sel", 32'(rs),  32'b001);

        // ICW1 mid-sequence restarts.
        do_write(1'b0, 8'h12);
        do_write(1'b0, 8'h13);
        do_write(1'b1, 8'h20);
        check("restart_flag", 32'(cw_flag),   32'd1);
        check("restart_init", 32'(init_done), 32'd0);
        do_write(1'b1, 8'h01);
        check("restart_done", 32'(init_done), 32'd1);

        // Read and write low together: the write wins.
        do_overlap(1'b1, 8'hA5, rs, act);
        check("overlap_read_sel", 32'(rs),      32'd0);
        check("overlap_rd_act",   32'(act),     32'd0);
        check("overlap_flag",     32'(cw_flag), 32'd4);
        check("overlap_data",     32'(cw_data), 32'hA5);

        // cs_n released before wr_n: no write.
        base = dut_strobes;
        do_abort(1'b1, 8'h77);
        check("abort_no_strobe", 32'(dut_strobes - base), 32'd0);
        check("abort_data",      32'(cw_data),            32'hA5);

        // Reset while waiting for ICW3.
        do_write(1'b0, 8'h11);
        do_write(1'b1, 8'h08);
        reset = 1'b1;
        tick(1);
        check("midrst_flag", 32'(cw_flag),   32'd7);
        check("midrst_data", 32'(cw_data),   32'd0);
        check("midrst_init", 32'(init_done), 32'd0);
        check("midrst_rsel", 32'(read_sel),  32'd0);
        reset = 1'b0;
        tick(S + 2);
        base = dut_strobes;
        do_write(1'b1, 8'h04);
        check("midrst_ignored", 32'(dut_strobes - base), 32'd0);
        check("midrst_flag2",   32'(cw_flag),            32'd7);

        // Randomized traffic.
        for (int it = 0; it < 300; it++) begin
            r   = $urandom_range(0, 9);
            rd8 = 8'($urandom_range(0, 255));
            case (r)
                0, 1:       do_write(1'b0, {rd8[7:5], 1'b1, rd8[3:0]});
                2, 3, 4, 5: do_write(1'($urandom_range(0, 1)), rd8);
                6, 7:       do_read(1'($urandom_range(0, 1)), rs, act);
                8:          do_abort(1'($urandom_range(0, 1)), rd8);
                default:    do_overlap(1'($urandom_range(0, 1)), rd8, rs, act);
            endcase
            tick($urandom_range(0, 3));
        end

        tick(10);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
